// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - Cab call/status bundle between the controller and its host
interface elevator_ctrl_if;
  logic [7:0] call_req;
  logic       emergency_stop;
  logic [2:0] floornum;
  logic [1:0] state;
  logic       door_open;
  logic [7:0] pending;

  modport master (
    output call_req,
    output emergency_stop,
    input  floornum,
    input  state,
    input  door_open,
    input  pending
  );

  modport slave (
    input  call_req,
    input  emergency_stop,
    output floornum,
    output state,
    output door_open,
    output pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN elevator motion controller
// Latches floor calls, times travel and door dwell, drives floor/direction display codes.
module elevator_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  elevator_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} fsm_t;

  localparam logic [1:0]       ST_IDLE     = 2'b00;
  localparam logic [1:0]       ST_UP       = 2'b01;
  localparam logic [1:0]       ST_DOWN     = 2'b10;
  localparam logic [2:0]       TOP_FLOOR   = 3'(NUM_FLOORS - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  fsm_t             fsm_q;
  logic             dir_up_q;
  logic [CNT_W-1:0] timer_q;
  logic [2:0]       floor_q;
  logic [7:0]       pending_q;
  logic [1:0]       state_q;
  logic             door_q;

  logic [7:0] pend_nxt;
  logic [7:0] pend_clr;
  logic [7:0] arr_clr;
  logic [2:0] arr_floor;
  logic       here_cur, above_cur, below_cur;
  logic       here_arr, above_arr, below_arr;
  logic       ahead_arr, behind_arr, fwd_cur, rev_cur;
  logic       travel_done, door_done, at_limit, moving_up;

  // Decisions look at the calls arriving on this edge as well as the latched ones.
  always_comb begin
    pend_nxt  = pending_q | bus.call_req;
    moving_up = (fsm_q == MOVE_UP);
    arr_floor = (fsm_q == MOVE_DOWN) ? floor_q - 3'd1 : floor_q + 3'd1;
    pend_clr  = pend_nxt & ~(8'b1 << floor_q);
    arr_clr   = pend_nxt & ~(8'b1 << arr_floor);
    here_cur  = pend_nxt[floor_q];
    here_arr  = pend_nxt[arr_floor];
    above_cur = 1'b0;
    below_cur = 1'b0;
    above_arr = 1'b0;
    below_arr = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q))   above_cur = above_cur | pend_nxt[i];
      if (i < int'(floor_q))   below_cur = below_cur | pend_nxt[i];
      if (i > int'(arr_floor)) above_arr = above_arr | pend_nxt[i];
      if (i < int'(arr_floor)) below_arr = below_arr | pend_nxt[i];
    end
    ahead_arr   = moving_up ? above_arr : below_arr;
    behind_arr  = moving_up ? below_arr : above_arr;
    fwd_cur     = dir_up_q ? above_cur : below_cur;
    rev_cur     = dir_up_q ? below_cur : above_cur;
    travel_done = (timer_q == TRAVEL_LAST);
    door_done   = (timer_q == DOOR_LAST);
    at_limit    = (moving_up && floor_q == TOP_FLOOR) ||
                  (fsm_q == MOVE_DOWN && floor_q == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      dir_up_q  <= 1'b1;
      timer_q   <= '0;
      floor_q   <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      door_q    <= 1'b0;
    end else if (bus.emergency_stop) begin
      // Frozen: only call latching continues; the display shows no motion.
      pending_q <= (fsm_q == DOOR) ? pend_clr : pend_nxt;
      state_q   <= ST_IDLE;
    end else begin
      case (fsm_q)
        IDLE: begin
          timer_q <= '0;
          if (here_cur) begin
            fsm_q     <= DOOR;
            door_q    <= 1'b1;
            pending_q <= pend_clr;
            state_q   <= ST_IDLE;
          end else begin
            pending_q <= pend_nxt;
            if (above_cur) begin
              fsm_q    <= MOVE_UP;
              dir_up_q <= 1'b1;
              state_q  <= ST_UP;
            end else if (below_cur) begin
              fsm_q    <= MOVE_DOWN;
              dir_up_q <= 1'b0;
              state_q  <= ST_DOWN;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        MOVE_UP, MOVE_DOWN: begin
          pending_q <= pend_nxt;
          if (!travel_done) begin
            timer_q <= timer_q + CNT_ONE;
            state_q <= moving_up ? ST_UP : ST_DOWN;
          end else if (at_limit) begin
            fsm_q   <= IDLE;
            timer_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            floor_q <= arr_floor;
            timer_q <= '0;
            if (here_arr) begin
              fsm_q     <= DOOR;
              door_q    <= 1'b1;
              pending_q <= arr_clr;
              state_q   <= ST_IDLE;
            end else if (ahead_arr) begin
              state_q <= moving_up ? ST_UP : ST_DOWN;
            end else if (behind_arr) begin
              fsm_q    <= moving_up ? MOVE_DOWN : MOVE_UP;
              dir_up_q <= !moving_up;
              state_q  <= moving_up ? ST_DOWN : ST_UP;
            end else begin
              fsm_q   <= IDLE;
              state_q <= ST_IDLE;
            end
          end
        end

        DOOR: begin
          pending_q <= pend_clr;
          state_q   <= ST_IDLE;
          if (bus.call_req[floor_q]) begin
            timer_q <= '0;
          end else if (!door_done) begin
            timer_q <= timer_q + CNT_ONE;
          end else begin
            door_q  <= 1'b0;
            timer_q <= '0;
            if (fwd_cur) begin
              fsm_q   <= dir_up_q ? MOVE_UP : MOVE_DOWN;
              state_q <= dir_up_q ? ST_UP : ST_DOWN;
            end else if (rev_cur) begin
              fsm_q    <= dir_up_q ? MOVE_DOWN : MOVE_UP;
              dir_up_q <= !dir_up_q;
              state_q  <= dir_up_q ? ST_DOWN : ST_UP;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end

        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.floornum  = floor_q;
  assign bus.state     = state_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - Directed vectors plus randomized run against a countdown reference model
module tb_elevator_ctrl;

  localparam int TRAVEL = 4;
  localparam int DWELL  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elevator_ctrl_if bus();

  elevator_ctrl #(
    .NUM_FLOORS(8),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DWELL),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] call;
    logic       es;
    int         n;
    logic [2:0] floor;
    logic [1:0] st;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[$];

  // Reference model: mode 0 idle, 1 up, 2 down, 3 door; m_left counts remaining cycles.
  int         m_floor, m_mode, m_left;
  bit         m_up, m_stopped;
  logic [7:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_floor = 0; m_mode = 0; m_left = 0; m_up = 1'b1; m_stopped = 1'b0; m_pend = '0;
  endtask

  function automatic bit reqs(input logic [7:0] p, input int f, input bit up);
    for (int i = 0; i < 8; i++)
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_stopped) return 2'b00;
    if (m_mode == 1) return 2'b01;
    if (m_mode == 2) return 2'b10;
    return 2'b00;
  endfunction

  // SCAN choice: keep the preferred way if calls lie there, else turn, else rest.
  task automatic go(input logic [7:0] p, input bit prefer_up);
    if (reqs(p, m_floor, prefer_up)) begin
      m_mode = prefer_up ? 1 : 2; m_up = prefer_up; m_left = TRAVEL;
    end else if (reqs(p, m_floor, !prefer_up)) begin
      m_mode = prefer_up ? 2 : 1; m_up = !prefer_up; m_left = TRAVEL;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic model_edge(input logic [7:0] call, input logic es);
    logic [7:0] pn;
    int nf;
    pn = m_pend | call;
    if (m_mode == 3) pn[m_floor] = 1'b0;
    if (es) begin
      m_pend = pn; m_stopped = 1'b1;
      return;
    end
    m_stopped = 1'b0;
    case (m_mode)
      0: begin
        if (pn[m_floor]) begin
          m_mode = 3; m_left = DWELL; pn[m_floor] = 1'b0;
        end else if (reqs(pn, m_floor, 1'b1)) begin
          m_mode = 1; m_up = 1'b1; m_left = TRAVEL;
        end else if (reqs(pn, m_floor, 1'b0)) begin
          m_mode = 2; m_up = 1'b0; m_left = TRAVEL;
        end
      end
      1, 2: begin
        m_left--;
        if (m_left == 0) begin
          nf = m_floor + ((m_mode == 1) ? 1 : -1);
          if (nf < 0 || nf > 7) begin
            m_mode = 0;
          end else begin
            m_floor = nf;
            if (pn[m_floor]) begin
              m_mode = 3; m_left = DWELL; pn[m_floor] = 1'b0;
            end else begin
              go(pn, m_mode == 1);
            end
          end
        end
      end
      default: begin
        if (call[m_floor]) begin
          m_left = DWELL;
        end else begin
          m_left--;
          if (m_left == 0) go(pn, m_up);
        end
      end
    endcase
    m_pend = pn;
  endtask

  task automatic check_model();
    check("model", {18'd0, bus.floornum, bus.state, bus.door_open, bus.pending},
          {18'd0, m_floor[2:0], m_state(), (m_mode == 3), m_pend});
  endtask

  task automatic step(input logic [7:0] call, input logic es);
    bus.call_req = call;
    bus.emergency_stop = es;
    @(posedge clk);
    model_edge(call, es);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [7:0] call, input logic es, input int n, input logic [2:0] floor,
                     input logic [1:0] st, input logic door, input logic [7:0] pend);
    vec_t v;
    v.call = call; v.es = es; v.n = n; v.floor = floor; v.st = st; v.door = door; v.pend = pend;
    tbl.push_back(v);
  endtask

  initial begin
    int es_left;
    logic [7:0] rc;

    rst_n = 1'b0;
    bus.call_req = '0;
    bus.emergency_stop = 1'b0;
    model_reset();

    // Single call to floor 3 from floor 0
    add(8'h08, 0, 1,  3'd0, 2'b01, 0, 8'h08);
    add(8'h00, 0, 3,  3'd0, 2'b01, 0, 8'h08);
    add(8'h00, 0, 1,  3'd1, 2'b01, 0, 8'h08);
    add(8'h00, 0, 4,  3'd2, 2'b01, 0, 8'h08);
    add(8'h00, 0, 4,  3'd3, 2'b00, 1, 8'h00);
    add(8'h00, 0, 5,  3'd3, 2'b00, 1, 8'h00);
    add(8'h00, 0, 1,  3'd3, 2'b00, 0, 8'h00);
    add(8'h00, 0, 3,  3'd3, 2'b00, 0, 8'h00);
    // At floor 3 heading up, calls at 5 and 1: serve 5 first
    add(8'h22, 0, 1,  3'd3, 2'b01, 0, 8'h22);
    add(8'h00, 0, 8,  3'd5, 2'b00, 1, 8'h02);
    add(8'h00, 0, 5,  3'd5, 2'b00, 1, 8'h02);
    add(8'h00, 0, 1,  3'd5, 2'b10, 0, 8'h02);
    add(8'h00, 0, 15, 3'd2, 2'b10, 0, 8'h02);
    add(8'h00, 0, 1,  3'd1, 2'b00, 1, 8'h00);
    add(8'h00, 0, 6,  3'd1, 2'b00, 0, 8'h00);
    // Door restart by a same-floor call at timer 4
    add(8'h02, 0, 1,  3'd1, 2'b00, 1, 8'h00);
    add(8'h00, 0, 4,  3'd1, 2'b00, 1, 8'h00);
    add(8'h02, 0, 1,  3'd1, 2'b00, 1, 8'h00);
    add(8'h00, 0, 5,  3'd1, 2'b00, 1, 8'h00);
    add(8'h00, 0, 1,  3'd1, 2'b00, 0, 8'h00);
    // Emergency stop two cycles into a move, with a call latched while frozen
    add(8'h10, 0, 1,  3'd1, 2'b01, 0, 8'h10);
    add(8'h00, 0, 2,  3'd1, 2'b01, 0, 8'h10);
    add(8'h01, 1, 10, 3'd1, 2'b00, 0, 8'h11);
    add(8'h00, 0, 1,  3'd1, 2'b01, 0, 8'h11);
    add(8'h00, 0, 1,  3'd2, 2'b01, 0, 8'h11);
    add(8'h00, 0, 8,  3'd4, 2'b00, 1, 8'h01);
    add(8'h00, 0, 6,  3'd4, 2'b10, 0, 8'h01);
    add(8'h00, 0, 16, 3'd0, 2'b00, 1, 8'h00);
    add(8'h00, 0, 6,  3'd0, 2'b00, 0, 8'h00);

    #2;
    check("reset_async", {24'd0, bus.floornum, bus.state, bus.door_open, bus.pending[1:0]}, 32'd0);
    check("reset_pending", {24'd0, bus.pending}, 32'd0);
    do_reset();

    for (int c = 0; c < 20; c++) begin
      step(8'h00, 1'b0);
      check("idle", {18'd0, bus.floornum, bus.state, bus.door_open, bus.pending}, 32'd0);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].call, tbl[r].es);
      for (int j = 1; j < tbl[r].n; j++) step(8'h00, tbl[r].es);
      check($sformatf("row%0d_floor", r), {29'd0, bus.floornum}, {29'd0, tbl[r].floor});
      check($sformatf("row%0d_state", r), {30'd0, bus.state}, {30'd0, tbl[r].st});
      check($sformatf("row%0d_door", r), {31'd0, bus.door_open}, {31'd0, tbl[r].door});
      check($sformatf("row%0d_pending", r), {24'd0, bus.pending}, {24'd0, tbl[r].pend});
    end

    es_left = 0;
    for (int c = 0; c < 3000; c++) begin
      rc = '0;
      if ($urandom_range(0, 9) == 0) rc[$urandom_range(0, 7)] = 1'b1;
      if (es_left > 0) es_left--;
      else if ($urandom_range(0, 79) == 0) es_left = $urandom_range(1, 12);
      step(rc, es_left > 0);
    end

    // Reset asserted mid-move at floor 2 with a call outstanding at floor 7
    do_reset();
    step(8'h80, 1'b0);
    for (int j = 0; j < 9; j++) step(8'h00, 1'b0);
    check("premove_floor", {29'd0, bus.floornum}, 32'd2);
    check("premove_pending", {24'd0, bus.pending}, 32'h80);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_outs", {18'd0, bus.floornum, bus.state, bus.door_open, bus.pending}, 32'd0);
    @(posedge clk);
    #1;
    check("midreset_hold", {18'd0, bus.floornum, bus.state, bus.door_open, bus.pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
